// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Optional bne support is built when the macro MC_BNE_EN is defined.
module multicycle_main_control #(
    parameter int ILLEGAL_TRAP = 1,
    parameter int STATE_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch,
    output logic               branch_ne,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal_op,
    output logic               halted,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPEEX,
        RTYPEWB,
        BEQEX,
        ADDIEX,
        ADDIWB,
        JEX,
`ifdef MC_BNE_EN
        BNEEX,
`endif
        HALT
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       halted;
        logic       fetch;
        logic       decode;
    } ctrl_t;

    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    logic   w_legal;

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
`ifdef MC_BNE_EN
        ok = ok || (op == OP_BNE);
`endif
        return ok;
    endfunction

    // Moore output table; registered against the next state so outputs line up with r_state.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
                c.fetch     = 1'b1;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.decode    = 1'b1;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            RTYPEEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            RTYPEWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BEQEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDIWB: begin
                c.reg_write = 1'b1;
            end
            JEX: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
`ifdef MC_BNE_EN
            BNEEX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch_ne = 1'b1;
            end
`endif
            HALT: begin
                c.halted = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign w_legal = is_legal(opcode);

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_ADDI:      w_next = ADDIEX;
                    OP_J:         w_next = JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       w_next = BNEEX;
`endif
                    default:      w_next = (ILLEGAL_TRAP != 0) ? HALT : FETCH;
                endcase
            end
            MEMADR:  w_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next = mem_ready ? MEMWB : MEMRD;
            MEMWR:   w_next = mem_ready ? FETCH : MEMWR;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = ADDIWB;
            HALT:    w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_ctrl  <= decode_ctrl(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_ctrl(w_next);
        end
    end

    // Strobes are masked by rst_n so they read 0 while reset is held; mux selects keep FETCH values.
    assign mem_req    = rst_n & r_ctrl.mem_req;
    assign mem_write  = rst_n & r_ctrl.mem_write;
    assign ir_write   = rst_n & r_ctrl.fetch & mem_ready;
    assign pc_write   = rst_n & (r_ctrl.pc_write | (r_ctrl.fetch & mem_ready));
    assign branch     = rst_n & r_ctrl.branch;
    assign reg_write  = rst_n & r_ctrl.reg_write;
    assign illegal_op = rst_n & r_ctrl.decode & ~w_legal;
`ifdef MC_BNE_EN
    assign branch_ne  = rst_n & r_ctrl.branch_ne;
`else
    assign branch_ne  = 1'b0;
`endif

    assign iord       = r_ctrl.iord;
    assign reg_dst    = r_ctrl.reg_dst;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign alu_src_a  = r_ctrl.alu_src_a;
    assign alu_src_b  = r_ctrl.alu_src_b;
    assign alu_op     = r_ctrl.alu_op;
    assign pc_src     = r_ctrl.pc_src;
    assign halted     = r_ctrl.halted;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: one trapping and one non-trapping instance share stimulus.
module tb_multicycle_main_control;

    typedef enum int {
        S_RST, S_FETCH, S_DECODE, S_DECILL, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTEX, S_RTWB, S_BEQ, S_ADDIEX, S_ADDIWB, S_JEX, S_BNE, S_HALT
    } tstate_t;

    typedef struct {
        logic [18:0] v;
        tstate_t     s;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    wire [18:0] vecA;
    wire [18:0] vecB;
    wire [3:0]  stateA;
    wire [3:0]  stateB;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   vectors;
    int   miscompares;

    multicycle_main_control #(.ILLEGAL_TRAP(1), .STATE_W(4)) dutA (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(vecA[18]), .mem_write(vecA[17]), .iord(vecA[16]), .ir_write(vecA[15]),
        .pc_write(vecA[14]), .branch(vecA[13]), .branch_ne(vecA[12]), .reg_write(vecA[11]),
        .reg_dst(vecA[10]), .mem_to_reg(vecA[9]), .alu_src_a(vecA[8]), .alu_src_b(vecA[7:6]),
        .alu_op(vecA[5:4]), .pc_src(vecA[3:2]), .illegal_op(vecA[1]), .halted(vecA[0]),
        .state(stateA)
    );

    multicycle_main_control #(.ILLEGAL_TRAP(0), .STATE_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(vecB[18]), .mem_write(vecB[17]), .iord(vecB[16]), .ir_write(vecB[15]),
        .pc_write(vecB[14]), .branch(vecB[13]), .branch_ne(vecB[12]), .reg_write(vecB[11]),
        .reg_dst(vecB[10]), .mem_to_reg(vecB[9]), .alu_src_a(vecB[8]), .alu_src_b(vecB[7:6]),
        .alu_op(vecB[5:4]), .pc_src(vecB[3:2]), .illegal_op(vecB[1]), .halted(vecB[0]),
        .state(stateB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-written output table per state, bit order matching vecA/vecB.
    function automatic logic [18:0] expVec(input tstate_t s, input logic mr);
        logic mreq, mwr, io, irw, pcw, br, brne, regw, rdst, m2r, srca, ill, hlt;
        logic [1:0] srcb, aop, psrc;
        {mreq, mwr, io, irw, pcw, br, brne, regw, rdst, m2r, srca, ill, hlt} = '0;
        srcb = 2'b00;
        aop  = 2'b00;
        psrc = 2'b00;
        case (s)
            S_RST:    srcb = 2'b01;
            S_FETCH:  begin mreq = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
            S_DECODE: srcb = 2'b11;
            S_DECILL: begin srcb = 2'b11; ill = 1'b1; end
            S_MEMADR: begin srca = 1'b1; srcb = 2'b10; end
            S_MEMRD:  begin mreq = 1'b1; io = 1'b1; end
            S_MEMWB:  begin regw = 1'b1; m2r = 1'b1; end
            S_MEMWR:  begin mreq = 1'b1; mwr = 1'b1; io = 1'b1; end
            S_RTEX:   begin srca = 1'b1; aop = 2'b10; end
            S_RTWB:   begin regw = 1'b1; rdst = 1'b1; end
            S_BEQ:    begin srca = 1'b1; aop = 2'b01; psrc = 2'b01; br = 1'b1; end
            S_ADDIEX: begin srca = 1'b1; srcb = 2'b10; end
            S_ADDIWB: regw = 1'b1;
            S_JEX:    begin psrc = 2'b10; pcw = 1'b1; end
            S_BNE:    begin srca = 1'b1; aop = 2'b01; psrc = 2'b01; brne = 1'b1; end
            S_HALT:   hlt = 1'b1;
            default:  ;
        endcase
        return {mreq, mwr, io, irw, pcw, br, brne, regw, rdst, m2r, srca, srcb, aop, psrc, ill, hlt};
    endfunction

    task automatic applyStimulus(input tstate_t sa, input tstate_t sb, input logic mr,
                                 input logic [5:0] op, input logic rst);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rst;
        mem_ready = mr;
        opcode    = op;
        e.v = expVec(sa, mr);
        e.s = sa;
        qa.push_back(e);
        e.v = expVec(sb, mr);
        e.s = sb;
        qb.push_back(e);
    endtask

    task automatic step(input tstate_t s, input logic mr, input logic [5:0] op);
        applyStimulus(s, s, mr, op, 1'b1);
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input logic [18:0] act);
        vectors++;
        if (act !== e.v) begin
            miscompares++;
            $display("[TB] FAIL %s %s: got %b required %b", tag, e.s.name(), act, e.v);
        end
    endtask

    task automatic illegalTest(input logic [5:0] op);
        applyStimulus(S_FETCH,  S_FETCH,  1'b1, op, 1'b1);
        applyStimulus(S_DECILL, S_DECILL, 1'b1, op, 1'b1);
        applyStimulus(S_HALT,   S_FETCH,  1'b1, op, 1'b1);
        applyStimulus(S_HALT,   S_DECILL, 1'b1, op, 1'b1);
        applyStimulus(S_HALT,   S_FETCH,  1'b1, op, 1'b1);
        applyStimulus(S_RST,    S_RST,    1'b1, 6'b000000, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle, so one entry is consumed per falling edge.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            checkOutput("A", ea, vecA);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            checkOutput("B", eb, vecB);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        mem_ready   = 1'b1;
        opcode      = 6'b000000;

        repeat (3) applyStimulus(S_RST, S_RST, 1'b1, 6'b000000, 1'b0);

        // R-type; opcode changes during RTYPEEX must be ignored.
        step(S_FETCH,  1'b1, 6'b000000);
        step(S_DECODE, 1'b1, 6'b000000);
        step(S_RTEX,   1'b1, 6'b100011);
        step(S_RTWB,   1'b1, 6'b000000);

        // lw with two wait cycles in MEMRD
        step(S_FETCH,  1'b1, 6'b100011);
        step(S_DECODE, 1'b1, 6'b100011);
        step(S_MEMADR, 1'b1, 6'b100011);
        step(S_MEMRD,  1'b0, 6'b000000);
        step(S_MEMRD,  1'b0, 6'b101011);
        step(S_MEMRD,  1'b1, 6'b000000);
        step(S_MEMWB,  1'b1, 6'b000000);

        // sw with a wait in FETCH and in MEMWR
        step(S_FETCH,  1'b0, 6'b101011);
        step(S_FETCH,  1'b1, 6'b101011);
        step(S_DECODE, 1'b1, 6'b101011);
        step(S_MEMADR, 1'b1, 6'b101011);
        step(S_MEMWR,  1'b0, 6'b101011);
        step(S_MEMWR,  1'b1, 6'b101011);

        step(S_FETCH,  1'b1, 6'b001000);
        step(S_DECODE, 1'b1, 6'b001000);
        step(S_ADDIEX, 1'b1, 6'b001000);
        step(S_ADDIWB, 1'b1, 6'b001000);

        step(S_FETCH,  1'b1, 6'b000100);
        step(S_DECODE, 1'b1, 6'b000100);
        step(S_BEQ,    1'b1, 6'b000100);

        step(S_FETCH,  1'b1, 6'b000010);
        step(S_DECODE, 1'b1, 6'b000010);
        step(S_JEX,    1'b1, 6'b000010);

`ifdef MC_BNE_EN
        step(S_FETCH,  1'b1, 6'b000101);
        step(S_DECODE, 1'b1, 6'b000101);
        step(S_BNE,    1'b1, 6'b000101);
`else
        illegalTest(6'b000101);
`endif

        illegalTest(6'b111111);

        // Reset while waiting in MEMRD, then a jump to confirm recovery.
        step(S_FETCH,  1'b1, 6'b100011);
        step(S_DECODE, 1'b1, 6'b100011);
        step(S_MEMADR, 1'b1, 6'b100011);
        step(S_MEMRD,  1'b0, 6'b100011);
        applyStimulus(S_RST, S_RST, 1'b0, 6'b000010, 1'b0);
        step(S_FETCH,  1'b1, 6'b000010);
        step(S_DECODE, 1'b1, 6'b000010);
        step(S_JEX,    1'b1, 6'b000010);

        repeat (2) @(negedge clk);
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d/%0d entries left, required 0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
